// File: rtl/force_release_arb_pkg.sv
// Shared definitions for the force/release override arbiter: state encoding
// and default sizing of the requester array, the forced net and hold counts.
package force_release_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORCE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int HW_DEF    = 8;

endpackage

// File: rtl/force_release_arb_rr_pick.sv
// Round-robin winner selection: the first set request bit at or after rr,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Walk from the farthest offset back to rr so the nearest request wins.
  always_comb begin
    int unsigned j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr) + k) % NREQ;
      if (req[j[IW-1:0]]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/force_release_arb.sv
// Override arbiter: grants one requester at a time the right to force a net
// to a latched value for a hold count, then releases with a done pulse.
module force_release_arb
  import force_release_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int HW    = HW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_val,
  input  logic [NREQ*HW-1:0]    req_hold,
  input  logic                  release_all,
  input  logic [WIDTH-1:0]      net_in,
  output logic [WIDTH-1:0]      net_out,
  output logic                  force_en,
  output logic [WIDTH-1:0]      force_val,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    rr, rr_nxt;
  logic [HW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] fval_nxt;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [HW-1:0]    pick_hold;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .rr    (rr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_hold = req_hold[int'(pick_idx)*HW +: HW];

  // State, owner, pointer, hold counter and latched value registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr        <= '0;
      cnt       <= '0;
      force_val <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr        <= rr_nxt;
      cnt       <= cnt_nxt;
      force_val <= fval_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down in FORCE, advance rr on release.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    fval_nxt  = force_val;
    case (state)
      IDLE: begin
        if (!release_all && pick_valid) begin
          owner_nxt = pick_idx;
          fval_nxt  = req_val[int'(pick_idx)*WIDTH +: WIDTH];
          cnt_nxt   = (pick_hold == '0) ? HW'(1) : pick_hold;
          state_nxt = FORCE;
        end
      end
      FORCE: begin
        cnt_nxt = cnt - HW'(1);
        if (cnt == HW'(1) || !req[owner] || release_all) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        rr_nxt    = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and done are one-hot decodes of the owner, gated by state.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state == FORCE)   gnt[owner]  = 1'b1;
    if (state == RELEASE) done[owner] = 1'b1;
  end

  assign force_en = (state == FORCE);
  assign busy     = (state != IDLE);
  assign net_out  = force_en ? force_val : net_in;

endmodule

// File: doc/force_release_arb.md
FORCE_RELEASE_ARB -- requirements
Module: force_release_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters sharing the override (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, giving the width of the overridden net.
REQ-003 SHALL have parameter HW, default 8, giving the width of each per-requester hold count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NREQ bits: per-requester force request, level-sensitive.
REQ-007 SHALL have port req_val, input, NREQ*WIDTH bits: packed force values; slice i belongs to requester i.
REQ-008 SHALL have port req_hold, input, NREQ*HW bits: packed hold counts in cycles; slice i belongs to requester i.
REQ-009 SHALL have port release_all, input, 1 bit: global abort of any active force.
REQ-010 SHALL have port net_in, input, WIDTH bits: the normally driven net value.
REQ-011 SHALL have port net_out, output, WIDTH bits: the resolved net, equal to force_val when force_en is 1, else net_in (combinational).
REQ-012 SHALL have port force_en, output, 1 bit: the override is active.
REQ-013 SHALL have port force_val, output, WIDTH bits: the latched override value.
REQ-014 SHALL have port gnt, output, NREQ bits: one-hot owner, high only while force_en is high.
REQ-015 SHALL have port done, output, NREQ bits: one-cycle pulse to the owner on release.
REQ-016 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, FORCE and RELEASE.
REQ-018 In IDLE with any req bit set, the block SHALL pick the winner by round-robin, starting the search at pointer rr.
REQ-019 On that same edge it SHALL latch owner, force_val = req_val[owner] and cnt = max(req_hold[owner], 1), then enter FORCE.
REQ-020 In FORCE, force_en SHALL be 1 and gnt[owner] SHALL be 1; cnt SHALL decrement by 1 each cycle.
REQ-021 FORCE SHALL exit to RELEASE on the edge where any of the following holds: cnt==1, req[owner]==0 (early release), or release_all==1.
REQ-022 Consequently, the override SHALL last exactly max(hold,1) cycles when uninterrupted.
REQ-023 In RELEASE, force_en SHALL be 0, gnt SHALL be 0 and done[owner] SHALL be 1 for exactly one cycle.
REQ-024 On leaving RELEASE, the block SHALL set rr = (owner+1) mod NREQ and return to IDLE.
REQ-025 A new grant SHALL therefore be issued no earlier than 2 cycles after the prior force ends (RELEASE followed by an IDLE arbitration edge).
REQ-026 The latency from req rising in IDLE to force_en high SHALL be 1 cycle.
REQ-027 force_val SHALL remain stable throughout FORCE; changes to req_val after the grant edge SHALL be ignored.
REQ-028 release_all asserted in IDLE SHALL suppress arbitration for that cycle.
REQ-029 release_all in RELEASE SHALL have no additional effect.
REQ-030 Simultaneous requests SHALL be resolved strictly round-robin; no requester waits more than NREQ grants.
REQ-031 rr SHALL wrap from NREQ-1 to 0.
REQ-032 A hold value of all ones SHALL be honoured without overflow; cnt SHALL be HW bits wide.

Reset
REQ-033 While reset is high at a clock edge, state SHALL become IDLE and force_en, gnt, done, busy, force_val, cnt, owner and rr SHALL become 0.
REQ-034 A reset asserted during FORCE SHALL drop force_en on the next edge without producing a done pulse; net_out then follows net_in.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=0, FORCE=1, RELEASE=2) and the default values of NREQ, WIDTH and HW.
REQ-036 The round-robin winner selection SHALL be a single combinational sub-module, rr_pick: inputs req and rr; outputs a valid flag and the index.

Verification
REQ-037 The bench SHALL check: req=4'b0001, val0=4'h5, hold0=3 -> force_en high for cycles 1-3 with net_out=4'h5, done[0] pulse in cycle 4, net_out==net_in afterward.
REQ-038 The bench SHALL check: req=4'b1111 held continuously, all holds 1 -> grants in order 0,1,2,3,0, one every 3 cycles.
REQ-039 The bench SHALL check: req0 with hold=10, req0 dropped in cycle 4 -> RELEASE in cycle 5, done[0] pulse, force lasted 4 cycles.
REQ-040 The bench SHALL check: release_all pulsed in cycle 2 of a hold=8 force -> force_en low from cycle 3, done pulse issued.
REQ-041 The bench SHALL check: hold=0 -> exactly 1 cycle of force; hold=8'hFF -> exactly 255 cycles.
REQ-042 The bench SHALL check: reset asserted mid-FORCE -> force_en, gnt and done all 0 on the next edge, rr=0, and the next grant goes to the lowest requesting index.
